// File: rtl/pipeio_mmio.sv
// Memory-mapped I/O unit for the pipelined CPU's MEM stage.
// Provides N_OUT writable output registers, N_IN synchronised input ports
// with sticky change flags, a reloadable down-counter timer and a maskable
// interrupt. Read data is combinational so the WB mux sees it in the same
// cycle the address is presented.
module pipeio_mmio #(
    parameter int DATA_W   = 32,
    parameter int N_IN     = 2,
    parameter int IN_W     = 6,
    parameter int N_OUT    = 4,
    parameter int IO_BIT   = 7,
    parameter int PRESCALE = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    we,
    input  logic [31:0]             addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic                    io_sel,
    output logic [DATA_W-1:0]       rdata,
    input  logic [N_IN*IN_W-1:0]    in_ports,
    output logic [N_OUT*DATA_W-1:0] out_ports,
    output logic                    irq
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [4:0] OFF_STATUS  = 5'd16;
    localparam logic [4:0] OFF_TCOUNT  = 5'd17;
    localparam logic [4:0] OFF_TCTRL   = 5'd18;
    localparam logic [4:0] OFF_TRELOAD = 5'd19;
    localparam logic [4:0] OFF_MASK    = 5'd20;

    logic [4:0]        offset;
    logic              wr_en;
    logic              unused_addr;

    logic [DATA_W-1:0] out_q   [N_OUT];
    logic [IN_W-1:0]   sync1_q [N_IN];
    logic [IN_W-1:0]   sync2_q [N_IN];
    logic [IN_W-1:0]   prev_q  [N_IN];

    logic [31:0]       status_q;
    logic [31:0]       mask_q;
    logic [DATA_W-1:0] tcount_q;
    logic [DATA_W-1:0] treload_q;
    logic [1:0]        tctrl_q;
    logic [PS_W-1:0]   presc_q;

    logic              tick;
    logic              timeout;
    logic [DATA_W-1:0] tcount_d;
    logic [PS_W-1:0]   presc_d;
    logic [31:0]       set_bits;
    logic [31:0]       clear_bits;

    assign io_sel      = addr[IO_BIT];
    assign offset      = addr[6:2];
    assign wr_en       = we & io_sel;
    assign unused_addr = ^addr;
    assign irq         = |(status_q & mask_q);

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_out
            assign out_ports[g*DATA_W +: DATA_W] = out_q[g];
        end
    endgenerate

    // Output registers capture store data addressed to their word offset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (wr_en && offset == 5'(i)) out_q[i] <= wdata;
            end
        end
    end

    // Two-flop synchroniser per input port plus a previous-value flop for edge detection
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_IN; i++) begin
                sync1_q[i] <= '0;
                sync2_q[i] <= '0;
                prev_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                sync1_q[i] <= in_ports[i*IN_W +: IN_W];
                sync2_q[i] <= sync1_q[i];
                prev_q[i]  <= sync2_q[i];
            end
        end
    end

    // Prescaler tick generation; counter sits at zero whenever the timer is disabled
    always_comb begin
        tick    = tctrl_q[0] && (presc_q == PS_W'(PRESCALE - 1));
        presc_d = presc_q;
        if (!tctrl_q[0] || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    // Timer countdown; a CPU write to TCOUNT overrides and swallows a coincident tick
    always_comb begin
        tcount_d = tcount_q;
        timeout  = 1'b0;
        if (wr_en && offset == OFF_TCOUNT) begin
            tcount_d = wdata;
        end else if (tick) begin
            if (tcount_q > DATA_W'(1)) begin
                tcount_d = tcount_q - DATA_W'(1);
            end else if (tcount_q == DATA_W'(1)) begin
                timeout  = 1'b1;
                tcount_d = tctrl_q[1] ? treload_q : '0;
            end
        end
    end

    // Sticky status sources and write-1-to-clear mask; new events override clears
    always_comb begin
        set_bits = '0;
        for (int i = 0; i < N_IN; i++) begin
            set_bits[i] = (sync2_q[i] != prev_q[i]);
        end
        set_bits[31] = timeout;
        clear_bits   = (wr_en && offset == OFF_STATUS) ? wdata[31:0] : '0;
    end

    // Timer, control, mask and status register updates
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            status_q  <= '0;
            mask_q    <= '0;
            tcount_q  <= '0;
            treload_q <= '0;
            tctrl_q   <= '0;
            presc_q   <= '0;
        end else begin
            status_q <= (status_q & ~clear_bits) | set_bits;
            tcount_q <= tcount_d;
            presc_q  <= presc_d;
            if (wr_en && offset == OFF_TCTRL)   tctrl_q   <= wdata[1:0];
            if (wr_en && offset == OFF_TRELOAD) treload_q <= wdata;
            if (wr_en && offset == OFF_MASK)    mask_q    <= wdata[31:0];
        end
    end

    // Combinational read mux; anything outside I/O space or unmapped reads zero
    always_comb begin
        rdata = '0;
        if (io_sel) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (offset == 5'(i)) rdata = out_q[i];
            end
            for (int i = 0; i < N_IN; i++) begin
                if (offset == 5'(8 + i)) rdata = DATA_W'(sync2_q[i]);
            end
            case (offset)
                OFF_STATUS:  rdata = DATA_W'(status_q);
                OFF_TCOUNT:  rdata = tcount_q;
                OFF_TCTRL:   rdata = DATA_W'(tctrl_q);
                OFF_TRELOAD: rdata = treload_q;
                OFF_MASK:    rdata = DATA_W'(mask_q);
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeio_mmio.sv
// Self-checking bench for pipeio_mmio: directed scenarios with literal
// expectations followed by randomized bus traffic and pin activity, all
// compared every cycle against a behavioural model of the register map.
module tb_pipeio_mmio;

    localparam int DATA_W   = 32;
    localparam int N_IN     = 2;
    localparam int IN_W     = 6;
    localparam int N_OUT    = 4;
    localparam int PRESCALE = 1;

    logic                    clock = 1'b0;
    logic                    resetn = 1'b1;
    logic                    we = 1'b0;
    logic [31:0]             addr = '0;
    logic [DATA_W-1:0]       wdata = '0;
    logic [N_IN*IN_W-1:0]    in_ports = '0;
    logic                    io_sel;
    logic [DATA_W-1:0]       rdata;
    logic [N_OUT*DATA_W-1:0] out_ports;
    logic                    irq;

    int checks   = 0;
    int failures = 0;

    pipeio_mmio #(
        .DATA_W(DATA_W), .N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT),
        .IO_BIT(7), .PRESCALE(PRESCALE)
    ) dut (
        .clock(clock), .resetn(resetn), .we(we), .addr(addr), .wdata(wdata),
        .io_sel(io_sel), .rdata(rdata), .in_ports(in_ports),
        .out_ports(out_ports), .irq(irq)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [31:0]          m_out [N_OUT];
    logic [31:0]          m_status, m_mask, m_tcount, m_treload;
    logic [1:0]           m_tctrl;
    int                   m_presc;
    logic [N_IN*IN_W-1:0] m_h0, m_h1, m_h2;

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) m_out[i] = '0;
        m_status = '0; m_mask = '0; m_tcount = '0; m_treload = '0;
        m_tctrl = '0; m_presc = 0;
        m_h0 = '0; m_h1 = '0; m_h2 = '0;
    endtask

    task automatic model_step();
        logic        wr;
        int          off;
        bit          tick;
        logic [31:0] set_b, clr_b, nt;
        wr    = we && addr[7];
        off   = int'(addr[6:2]);
        tick  = m_tctrl[0] && (m_presc == PRESCALE - 1);
        set_b = '0;
        clr_b = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (m_h1[i*IN_W +: IN_W] != m_h2[i*IN_W +: IN_W]) set_b[i] = 1'b1;
        end
        if (wr && off == 17) nt = wdata;
        else if (tick && m_tcount > 1) nt = m_tcount - 1;
        else if (tick && m_tcount == 1) begin
            nt = m_tctrl[1] ? m_treload : 32'd0;
            set_b[31] = 1'b1;
        end else nt = m_tcount;
        if (wr && off == 16) clr_b = wdata;
        if (!m_tctrl[0] || tick) m_presc = 0;
        else m_presc = m_presc + 1;
        if (wr && off < N_OUT) m_out[off] = wdata;
        m_status = (m_status & ~clr_b) | set_b;
        m_tcount = nt;
        if (wr && off == 18) m_tctrl = wdata[1:0];
        if (wr && off == 19) m_treload = wdata;
        if (wr && off == 20) m_mask = wdata;
        m_h2 = m_h1;
        m_h1 = m_h0;
        m_h0 = in_ports;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        int off;
        if (!a[7]) return 32'd0;
        off = int'(a[6:2]);
        if (off < N_OUT) return m_out[off];
        if (off >= 8 && off < 8 + N_IN) return 32'(m_h1[(off-8)*IN_W +: IN_W]);
        case (off)
            16: return m_status;
            17: return m_tcount;
            18: return {30'd0, m_tctrl};
            19: return m_treload;
            20: return m_mask;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edges as the DUT, including async reset
    always @(posedge clock or negedge resetn) begin
        if (!resetn) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        check_output("io_sel", {31'd0, io_sel}, {31'd0, addr[7]});
        check_output("rdata", rdata, exp_rdata(addr));
        check_output("irq", {31'd0, irq}, {31'd0, |(m_status & m_mask)});
        for (int i = 0; i < N_OUT; i++) begin
            check_output($sformatf("out_port%0d", i), out_ports[i*DATA_W +: DATA_W], m_out[i]);
        end
    end

    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        #1;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] exp, input string name);
        apply_stimulus(1'b0, a, 32'd0);
        #1;
        check_output(name, rdata, exp);
    endtask

    int offs [16] = '{0, 1, 2, 3, 4, 8, 9, 10, 16, 17, 18, 19, 20, 21, 25, 31};

    initial begin
        logic [31:0] r, a, d;
        int off;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 resetn = 1'b1;

        // Output register write, readback, async reset
        apply_stimulus(1'b1, 32'h84, 32'hA5);
        read_expect(32'h84, 32'hA5, "t1_out1_readback");
        check_output("t1_port1", out_ports[63:32], 32'hA5);
        check_output("t1_port0", out_ports[31:0], 32'h0);
        resetn = 1'b0;
        #1;
        check_output("t1_async_reset_port1", out_ports[63:32], 32'h0);
        check_output("t1_async_reset_irq", {31'd0, irq}, 32'h0);
        @(negedge clock);
        #1 resetn = 1'b1;

        // Input synchroniser latency and sticky change flags
        apply_stimulus(1'b1, 32'hD0, 32'h1);
        apply_stimulus(1'b0, 32'hA0, 32'h0);
        in_ports[5:0] = 6'h2A;
        #1 check_output("t2_in0_edge0", rdata, 32'h0);
        read_expect(32'hA0, 32'h0, "t2_in0_edge1");
        read_expect(32'hA0, 32'h2A, "t2_in0_edge2");
        check_output("t2_irq_edge2", {31'd0, irq}, 32'h0);
        read_expect(32'hC0, 32'h1, "t2_status_edge3");
        check_output("t2_irq_edge3", {31'd0, irq}, 32'h1);
        apply_stimulus(1'b1, 32'hC0, 32'h1);
        read_expect(32'hC0, 32'h0, "t2_w1c");
        check_output("t2_irq_cleared", {31'd0, irq}, 32'h0);
        apply_stimulus(1'b0, 32'hC0, 32'h0);
        in_ports[5:0] = 6'h15;
        apply_stimulus(1'b0, 32'hC0, 32'h0);
        apply_stimulus(1'b1, 32'hC0, 32'h1);
        read_expect(32'hC0, 32'h1, "t2_set_beats_clear");
        apply_stimulus(1'b1, 32'hC0, 32'hFFFF_FFFF);

        // Auto-reload timer with interrupt
        apply_stimulus(1'b1, 32'hCC, 32'd3);
        apply_stimulus(1'b1, 32'hC4, 32'd3);
        apply_stimulus(1'b1, 32'hD0, 32'h8000_0000);
        apply_stimulus(1'b1, 32'hC8, 32'd3);
        read_expect(32'hC4, 32'd3, "t3_count3");
        read_expect(32'hC4, 32'd2, "t3_count2");
        read_expect(32'hC4, 32'd1, "t3_count1");
        read_expect(32'hC0, 32'h8000_0000, "t3_first_expiry");
        check_output("t3_irq_set", {31'd0, irq}, 32'h1);
        apply_stimulus(1'b1, 32'hC0, 32'h8000_0000);
        #1 check_output("t3_irq_before_clear", {31'd0, irq}, 32'h1);
        read_expect(32'hC0, 32'h0, "t3_w1c");
        check_output("t3_irq_dropped", {31'd0, irq}, 32'h0);
        read_expect(32'hC0, 32'h8000_0000, "t3_second_expiry");
        apply_stimulus(1'b1, 32'hC8, 32'd0);
        apply_stimulus(1'b1, 32'hC0, 32'hFFFF_FFFF);

        // One-shot timer
        apply_stimulus(1'b1, 32'hC4, 32'd2);
        apply_stimulus(1'b1, 32'hC8, 32'd1);
        read_expect(32'hC4, 32'd2, "t4_count2");
        read_expect(32'hC4, 32'd1, "t4_count1");
        read_expect(32'hC0, 32'h8000_0000, "t4_expiry");
        read_expect(32'hC4, 32'd0, "t4_count_stuck0");
        apply_stimulus(1'b1, 32'hC0, 32'h8000_0000);
        for (int i = 0; i < 20; i++) read_expect(32'hC0, 32'h0, "t4_no_refire");
        read_expect(32'hC8, 32'd1, "t4_tctrl_readback");

        // CPU write to TCOUNT beats a coincident tick
        apply_stimulus(1'b1, 32'hC4, 32'd1);
        apply_stimulus(1'b1, 32'hC4, 32'd5);
        read_expect(32'hC4, 32'd5, "t5_write_wins");
        read_expect(32'hC0, 32'h0, "t5_no_flag");
        apply_stimulus(1'b1, 32'hC8, 32'd0);

        // Unmapped offsets and accesses outside I/O space
        read_expect(32'h80 | (32'd25 << 2), 32'h0, "t6_unmapped25");
        apply_stimulus(1'b1, 32'h80 | (32'd25 << 2), 32'hFFFF_FFFF);
        apply_stimulus(1'b1, 32'h90, 32'h1234);
        apply_stimulus(1'b1, 32'h00, 32'hDEAD);
        #1;
        check_output("t6_io_sel_low", {31'd0, io_sel}, 32'h0);
        check_output("t6_rdata_outside", rdata, 32'h0);
        read_expect(32'h80, 32'h0, "t6_out0_unchanged");
        read_expect(32'h90, 32'h0, "t6_offset4_unmapped");
        check_output("t6_port0", out_ports[31:0], 32'h0);

        // Randomized traffic checked by the every-cycle compare
        for (int n = 0; n < 2000; n++) begin
            off = offs[$urandom_range(0, 15)];
            a = $urandom();
            a[7] = ($urandom_range(0, 7) != 0);
            a[6:2] = 5'(off);
            if (off == 17 || off == 19) d = $urandom_range(0, 6);
            else if (off == 18) d = $urandom_range(0, 7);
            else d = $urandom();
            apply_stimulus(1'($urandom_range(0, 1)), a, d);
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom();
                in_ports = r[N_IN*IN_W-1:0];
            end
            if (n == 1000) begin
                resetn = 1'b0;
                apply_stimulus(1'b0, 32'h0, 32'h0);
                apply_stimulus(1'b0, 32'h0, 32'h0);
                resetn = 1'b1;
            end
        end

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
